// File: rtl/iitk_mini_mips_core.sv
// Register file: 32 GPRs (r0 hardwired to zero) plus HI/LO multiply result registers.
// Latency: combinational reads, writes commit on the rising clock edge.
// Backpressure: none, one write per cycle always accepted.
module iitk_mini_mips_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        hilo_we,
  input  logic [31:0] hi_wd,
  input  logic [31:0] lo_wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] registers [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];

  // Only r0 is forced on reset so values loaded before reset release survive.
  always_ff @(posedge clk) begin
    if (reset) begin
      registers[0] <= 32'd0;
    end else if (we && (wa != 5'd0)) begin
      registers[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (hilo_we) begin
      hi <= hi_wd;
      lo <= lo_wd;
    end
  end

endmodule

// Single-cycle MIPS-subset core with private instruction and data memories.
// Latency: one instruction per clock, all architectural state commits on the same edge.
// Backpressure: none, the core never stalls.
module iitk_mini_mips_core #(
  parameter int    IMEM_WORDS = 256,
  parameter int    DMEM_WORDS = 256,
  parameter string IMEM_FILE  = ""
) (
  input logic clk,
  input logic reset
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] imem [0:IMEM_WORDS-1];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  logic [31:0] pc_out;
  logic [31:0] pc4;
  logic [31:0] pc_next;
  logic [31:0] instruction;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [5:0]  funct;
  logic [31:0] simm;
  logic [25:0] target;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi_val;
  logic [31:0] lo_val;
  logic [31:0] mem_addr;
  logic [31:0] dmem_rd;
  logic [31:0] br_target;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        hilo_we;
  logic [31:0] hi_wd;
  logic [31:0] lo_wd;
  logic        dmem_we;

  assign instruction = imem[pc_out[IAW+1:2]];
  assign pc4         = pc_out + 32'd4;

  assign op     = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign sh     = instruction[10:6];
  assign funct  = instruction[5:0];
  assign simm   = {{16{instruction[15]}}, instruction[15:0]};
  assign target = instruction[25:0];

  iitk_mini_mips_rf rf_inst (
    .clk     (clk),
    .reset   (reset),
    .ra1     (rs),
    .ra2     (rt),
    .we      (rf_we),
    .wa      (rf_wa),
    .wd      (rf_wd),
    .hilo_we (hilo_we),
    .hi_wd   (hi_wd),
    .lo_wd   (lo_wd),
    .rd1     (rs_val),
    .rd2     (rt_val),
    .hi      (hi_val),
    .lo      (lo_val)
  );

  assign mem_addr  = rs_val + simm;
  assign dmem_rd   = dmem[mem_addr[DAW+1:2]];
  assign br_target = pc4 + {simm[29:0], 2'b00};
  // 64-bit operands keep the low 64 bits of the product exact for both signednesses.
  assign prod_s    = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u    = {32'd0, rs_val} * {32'd0, rt_val};

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:DAW+2], mem_addr[1:0]};

  always_comb begin
    rf_we   = 1'b0;
    rf_wa   = rd;
    rf_wd   = 32'd0;
    hilo_we = 1'b0;
    hi_wd   = 32'd0;
    lo_wd   = 32'd0;
    dmem_we = 1'b0;
    pc_next = pc4;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin rf_we = 1'b1; rf_wd = rs_val + rt_val; end
          6'h22: begin rf_we = 1'b1; rf_wd = rs_val - rt_val; end
          6'h24: begin rf_we = 1'b1; rf_wd = rs_val & rt_val; end
          6'h25: begin rf_we = 1'b1; rf_wd = rs_val | rt_val; end
          6'h2A: begin
            rf_we = 1'b1;
            rf_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
          end
          6'h00: begin rf_we = 1'b1; rf_wd = rt_val << sh; end
          6'h18: begin hilo_we = 1'b1; {hi_wd, lo_wd} = prod_s; end
          6'h19: begin hilo_we = 1'b1; {hi_wd, lo_wd} = prod_u; end
          6'h10: begin rf_we = 1'b1; rf_wd = hi_val; end
          6'h12: begin rf_we = 1'b1; rf_wd = lo_val; end
          default: ;
        endcase
      end
      6'h08: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val + simm; end
      6'h23: begin rf_we = 1'b1; rf_wa = rt; rf_wd = dmem_rd; end
      6'h2B: dmem_we = 1'b1;
      6'h04: if (rs_val == rt_val) pc_next = br_target;
      6'h05: if (rs_val != rt_val) pc_next = br_target;
      6'h02: pc_next = {pc4[31:28], target, 2'b00};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_out <= 32'd0;
    else       pc_out <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (!reset && dmem_we) dmem[mem_addr[DAW+1:2]] <= rt_val;
  end

endmodule

// File: tb/tb_iitk_mini_mips_core.sv
// Directed checks of the multiply/HI/LO path and reset, then random programs against an ISA-level model.
module tb_iitk_mini_mips_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  iitk_mini_mips_core #(
    .IMEM_WORDS (256),
    .DMEM_WORDS (256),
    .IMEM_FILE  ("")
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_imem [256];
  logic [31:0] m_mem  [256];
  logic [31:0] m_pc, m_hi, m_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                        logic [4:0] sa, logic [5:0] fn);
    return {6'h00, s, t, d, sa, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] o, logic [4:0] s, logic [4:0] t,
                                        logic [15:0] imm);
    return {o, s, t, imm};
  endfunction

  task automatic load(input int a, input logic [31:0] w);
    dut.imem[a] = w;
    m_imem[a]   = w;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Architectural interpreter: executes the instruction at m_pc and advances it.
  task automatic model_step();
    logic [31:0] ins, a, b, se, pc4, addr;
    logic [63:0] p;
    ins  = m_imem[m_pc[9:2]];
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    se   = {{16{ins[15]}}, ins[15:0]};
    addr = a + se;
    pc4  = m_pc + 32'd4;
    m_pc = pc4;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20: wr(ins[15:11], a + b);
        6'h22: wr(ins[15:11], a - b);
        6'h24: wr(ins[15:11], a & b);
        6'h25: wr(ins[15:11], a | b);
        6'h2A: wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h00: wr(ins[15:11], b << ins[10:6]);
        6'h18: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
        6'h19: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); {m_hi, m_lo} = p; end
        6'h10: wr(ins[15:11], m_hi);
        6'h12: wr(ins[15:11], m_lo);
        default: ;
      endcase
      6'h08: wr(ins[20:16], addr);
      6'h23: wr(ins[20:16], m_mem[addr[9:2]]);
      6'h2B: m_mem[addr[9:2]] = b;
      6'h04: if (a == b) m_pc = pc4 + (se << 2);
      6'h05: if (a != b) m_pc = pc4 + (se << 2);
      6'h02: m_pc = {pc4[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  a, b, d, sa;
    logic [15:0] imm;
    int off;
    a   = 5'($urandom_range(0, 15));
    b   = 5'($urandom_range(0, 15));
    d   = 5'($urandom_range(0, 15));
    sa  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    off = int'($urandom_range(0, 16)) - 8;
    case ($urandom_range(0, 17))
      0:  return r_ins(a, b, d, 5'd0, 6'h20);
      1:  return r_ins(a, b, d, 5'd0, 6'h22);
      2:  return r_ins(a, b, d, 5'd0, 6'h24);
      3:  return r_ins(a, b, d, 5'd0, 6'h25);
      4:  return r_ins(a, b, d, 5'd0, 6'h2A);
      5:  return r_ins(5'd0, b, d, sa, 6'h00);
      6:  return r_ins(a, b, d, 5'd0, 6'h18);
      7:  return r_ins(a, b, d, 5'd0, 6'h19);
      8:  return r_ins(5'd0, 5'd0, d, 5'd0, 6'h10);
      9:  return r_ins(5'd0, 5'd0, d, 5'd0, 6'h12);
      10: return i_ins(6'h08, a, b, imm);
      11: return i_ins(6'h23, a, b, imm);
      12: return i_ins(6'h2B, a, b, imm);
      13: return i_ins(6'h04, a, ($urandom_range(0, 1) == 1) ? a : b, off[15:0]);
      14: return i_ins(6'h05, a, b, off[15:0]);
      15: return {6'h02, 26'($urandom_range(0, 70))};
      16: return r_ins(a, b, d, 5'd0, 6'h3F);
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  task automatic check_all();
    chk("pc", dut.pc_out, m_pc);
    chk("instr", dut.instruction, m_imem[m_pc[9:2]]);
    chk("hi", dut.rf_inst.hi, m_hi);
    chk("lo", dut.rf_inst.lo, m_lo);
    for (int r = 0; r < 32; r++) chk($sformatf("r%0d", r), dut.rf_inst.registers[r], m_reg[r]);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      load(i, 32'd0);
      dut.dmem[i] = 32'd0;
    end
    load(0, r_ins(5'd8,  5'd9,  5'd0,  5'd0, 6'h18));
    load(1, r_ins(5'd0,  5'd0,  5'd12, 5'd0, 6'h12));
    load(2, r_ins(5'd10, 5'd11, 5'd0,  5'd0, 6'h18));
    load(3, r_ins(5'd8,  5'd10, 5'd0,  5'd0, 6'h18));
    load(4, r_ins(5'd10, 5'd11, 5'd0,  5'd0, 6'h19));
    load(5, r_ins(5'd0,  5'd0,  5'd13, 5'd0, 6'h10));
    load(6, i_ins(6'h08, 5'd0, 5'd0, 16'd5));
    load(7, r_ins(5'd0,  5'd0,  5'd14, 5'd0, 6'h20));
    load(8, i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF));
    for (int r = 1; r < 32; r++) dut.rf_inst.registers[r] = 32'd0;
    dut.rf_inst.registers[8]  = 32'd5;
    dut.rf_inst.registers[9]  = 32'd7;
    dut.rf_inst.registers[10] = 32'hFFFFFFFF;
    dut.rf_inst.registers[11] = 32'hFFFFFFFE;
    dut.rf_inst.registers[14] = 32'h00001234;

    step();
    chk("reset_pc", dut.pc_out, 32'd0);
    chk("reset_hi", dut.rf_inst.hi, 32'd0);
    chk("reset_lo", dut.rf_inst.lo, 32'd0);
    chk("reset_r0", dut.rf_inst.registers[0], 32'd0);
    reset = 1'b0;

    step();
    chk("mult57_hi", dut.rf_inst.hi, 32'h00000000);
    chk("mult57_lo", dut.rf_inst.lo, 32'h00000023);
    chk("mult57_pc", dut.pc_out, 32'd4);
    chk("keep_r8",  dut.rf_inst.registers[8],  32'd5);
    chk("keep_r9",  dut.rf_inst.registers[9],  32'd7);
    chk("keep_r10", dut.rf_inst.registers[10], 32'hFFFFFFFF);
    chk("keep_r11", dut.rf_inst.registers[11], 32'hFFFFFFFE);
    step();
    chk("mflo_r12", dut.rf_inst.registers[12], 32'h00000023);
    step();
    chk("mult_m1m2_hi", dut.rf_inst.hi, 32'h00000000);
    chk("mult_m1m2_lo", dut.rf_inst.lo, 32'h00000002);
    step();
    chk("mult_5m1_hi", dut.rf_inst.hi, 32'hFFFFFFFF);
    chk("mult_5m1_lo", dut.rf_inst.lo, 32'hFFFFFFFB);
    step();
    chk("multu_hi", dut.rf_inst.hi, 32'hFFFFFFFD);
    chk("multu_lo", dut.rf_inst.lo, 32'h00000002);
    step();
    chk("mfhi_r13", dut.rf_inst.registers[13], 32'hFFFFFFFD);
    step();
    chk("addi_r0", dut.rf_inst.registers[0], 32'd0);
    chk("addi_r0_pc", dut.pc_out, 32'h1C);
    step();
    chk("add_r14", dut.rf_inst.registers[14], 32'd0);
    chk("beq_pc0", dut.pc_out, 32'h20);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("beq_self_pc", dut.pc_out, 32'h20);
    end

    reset = 1'b1;
    step();
    chk("midrst_pc", dut.pc_out, 32'd0);
    chk("midrst_hi", dut.rf_inst.hi, 32'd0);
    chk("midrst_lo", dut.rf_inst.lo, 32'd0);
    chk("midrst_r12", dut.rf_inst.registers[12], 32'h00000023);
    chk("midrst_r13", dut.rf_inst.registers[13], 32'hFFFFFFFD);
    chk("midrst_r8", dut.rf_inst.registers[8], 32'd5);
    reset = 1'b0;
    step();
    chk("restart_pc", dut.pc_out, 32'd4);
    chk("restart_lo", dut.rf_inst.lo, 32'h00000023);

    for (int round = 0; round < 3; round++) begin
      reset = 1'b1;
      for (int i = 0; i < 256; i++) begin
        load(i, (i < 64) ? rand_ins() : 32'd0);
        dut.dmem[i] = 32'd0;
        m_mem[i]    = 32'd0;
      end
      m_reg[0] = 32'd0;
      for (int r = 1; r < 32; r++) begin
        m_reg[r] = $urandom;
        if (r == 1) m_reg[r] = 32'hFFFFFFFF;
        if (r == 2) m_reg[r] = 32'h80000000;
        dut.rf_inst.registers[r] = m_reg[r];
      end
      step();
      m_pc = 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      check_all();
      reset = 1'b0;
      for (int s = 0; s < 200; s++) begin
        model_step();
        step();
        check_all();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
